// File: rtl/data_ram_arbiter.sv
// rtl/data_ram_arbiter.sv - shares the data RAM between the core port and a debug burst-read engine
// Core has priority; a streak counter forces a debug beat after MAX_CORE_STREAK core wins.
module data_ram_arbiter #(
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] DATA_RAM_START = 32'h0010_0000,
    parameter logic [XLEN-1:0] DATA_RAM_END = 32'h0011_0000,
    parameter int MAX_CORE_STREAK = 4,
    parameter int BURST_LEN_W = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_core_req,
    input  logic                   i_core_we,
    input  logic [XLEN-1:0]        i_core_addr,
    input  logic [XLEN-1:0]        i_core_wdata,
    input  logic [XLEN/8-1:0]      i_core_be,
    output logic                   o_core_gnt,
    output logic                   o_core_rvalid,
    output logic [XLEN-1:0]        o_core_rdata,
    output logic                   o_core_err,
    input  logic                   i_dbg_start,
    input  logic [XLEN-1:0]        i_dbg_addr,
    input  logic [BURST_LEN_W-1:0] i_dbg_len,
    output logic                   o_dbg_busy,
    output logic                   o_dbg_rvalid,
    output logic [XLEN-1:0]        o_dbg_rdata,
    output logic                   o_dbg_done,
    output logic                   o_dbg_err,
    output logic                   o_ram_en,
    output logic                   o_ram_we,
    output logic [XLEN-1:0]        o_ram_addr,
    output logic [XLEN-1:0]        o_ram_wdata,
    output logic [XLEN/8-1:0]      o_ram_be,
    input  logic [XLEN-1:0]        i_ram_rdata
);

    localparam int SW = $clog2(MAX_CORE_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_CORE_STREAK);

    typedef enum logic [1:0] {IDLE, BURST, DRAIN, FINISH} state_t;

    state_t                 state, state_nxt;
    logic [XLEN-1:0]        dbg_addr, dbg_addr_nxt;
    logic [BURST_LEN_W-1:0] remaining, remaining_nxt;
    logic                   err_flag, err_flag_nxt;
    logic [SW-1:0]          streak, streak_nxt;
    logic                   rsp_valid, rsp_owner, rsp_err;

    logic core_in_range, beat_in_range, pending, core_win, dbg_win;

    assign core_in_range = (i_core_addr >= DATA_RAM_START) && (i_core_addr < DATA_RAM_END);
    assign beat_in_range = (dbg_addr >= DATA_RAM_START) && (dbg_addr < DATA_RAM_END);
    assign pending       = (state == BURST) && (remaining != '0);
    assign core_win      = !i_rst && i_core_req && !(pending && (streak == STREAK_MAX));
    assign dbg_win       = !i_rst && pending && !core_win;

    always_comb begin
        state_nxt     = state;
        dbg_addr_nxt  = dbg_addr;
        remaining_nxt = remaining;
        err_flag_nxt  = err_flag;
        streak_nxt    = streak;
        o_ram_en      = 1'b0;
        o_ram_we      = 1'b0;
        o_ram_addr    = '0;
        o_ram_wdata   = '0;
        o_ram_be      = '0;

        if (core_win) begin
            if (core_in_range) begin
                o_ram_en    = 1'b1;
                o_ram_we    = i_core_we;
                o_ram_addr  = i_core_addr;
                o_ram_wdata = i_core_wdata;
                o_ram_be    = i_core_be;
            end
        end else if (dbg_win && beat_in_range) begin
            o_ram_en   = 1'b1;
            o_ram_addr = dbg_addr;
            o_ram_be   = '1;
        end

        if (!pending || dbg_win) begin
            streak_nxt = '0;
        end else if (core_win && (streak != STREAK_MAX)) begin
            streak_nxt = streak + SW'(1);
        end

        case (state)
            IDLE: begin
                if (i_dbg_start) begin
                    dbg_addr_nxt  = i_dbg_addr & ~XLEN'(3);
                    remaining_nxt = i_dbg_len;
                    err_flag_nxt  = 1'b0;
                    state_nxt     = (i_dbg_len == '0) ? FINISH : BURST;
                end
            end
            BURST: begin
                if (dbg_win) begin
                    if (beat_in_range) begin
                        dbg_addr_nxt  = dbg_addr + XLEN'(4);
                        remaining_nxt = remaining - BURST_LEN_W'(1);
                        if (remaining == BURST_LEN_W'(1)) begin
                            state_nxt = DRAIN;
                        end
                    end else begin
                        err_flag_nxt = 1'b1;
                        state_nxt    = FINISH;
                    end
                end
            end
            DRAIN:   state_nxt = IDLE;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Single outstanding read: owner 1 routes the returning word to the debug engine.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            dbg_addr  <= '0;
            remaining <= '0;
            err_flag  <= 1'b0;
            streak    <= '0;
            rsp_valid <= 1'b0;
            rsp_owner <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            dbg_addr  <= dbg_addr_nxt;
            remaining <= remaining_nxt;
            err_flag  <= err_flag_nxt;
            streak    <= streak_nxt;
            rsp_valid <= (core_win && (!i_core_we || !core_in_range)) || (dbg_win && beat_in_range);
            rsp_owner <= dbg_win;
            rsp_err   <= core_win && !core_in_range;
        end
    end

    assign o_core_gnt    = core_win;
    assign o_core_rvalid = rsp_valid && !rsp_owner;
    assign o_core_err    = o_core_rvalid && rsp_err;
    assign o_core_rdata  = (o_core_rvalid && !rsp_err) ? i_ram_rdata : '0;
    assign o_dbg_rvalid  = rsp_valid && rsp_owner;
    assign o_dbg_rdata   = o_dbg_rvalid ? i_ram_rdata : '0;
    assign o_dbg_busy    = (state != IDLE);
    assign o_dbg_done    = (state == DRAIN) || (state == FINISH);
    assign o_dbg_err     = (state == FINISH) && err_flag;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// tb/tb_data_ram_arbiter.sv - self-checking bench for data_ram_arbiter
// Directed scenarios followed by randomized traffic against a queue-based reference model.
module tb_data_ram_arbiter;

    localparam logic [31:0] START = 32'h0010_0000;
    localparam logic [31:0] END_A = 32'h0011_0000;
    localparam int MAXS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req, core_we, core_gnt, core_rvalid, core_err;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic [3:0]  core_be;
    logic        dbg_start, dbg_busy, dbg_rvalid, dbg_done, dbg_err;
    logic [31:0] dbg_addr, dbg_rdata;
    logic [7:0]  dbg_len;
    logic        ram_en, ram_we;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic [3:0]  ram_be;
    logic [140:0] outs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_ram_arbiter dut (
        .i_clk(clk), .i_rst(rst),
        .i_core_req(core_req), .i_core_we(core_we), .i_core_addr(core_addr),
        .i_core_wdata(core_wdata), .i_core_be(core_be),
        .o_core_gnt(core_gnt), .o_core_rvalid(core_rvalid), .o_core_rdata(core_rdata),
        .o_core_err(core_err),
        .i_dbg_start(dbg_start), .i_dbg_addr(dbg_addr), .i_dbg_len(dbg_len),
        .o_dbg_busy(dbg_busy), .o_dbg_rvalid(dbg_rvalid), .o_dbg_rdata(dbg_rdata),
        .o_dbg_done(dbg_done), .o_dbg_err(dbg_err),
        .o_ram_en(ram_en), .o_ram_we(ram_we), .o_ram_addr(ram_addr),
        .o_ram_wdata(ram_wdata), .o_ram_be(ram_be), .i_ram_rdata(ram_rdata)
    );

    assign outs = {core_gnt, core_rvalid, core_rdata, core_err, dbg_busy, dbg_rvalid, dbg_rdata,
                   dbg_done, dbg_err, ram_en, ram_we, ram_addr, ram_wdata, ram_be};

    // RAM seen by the DUT (mem) and the bench's own expectation of its contents (gmem)
    logic [31:0] mem  [logic [29:0]];
    logic [31:0] gmem [logic [29:0]];

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'hA5A5_5A5A;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        logic [29:0] k = a[31:2];
        return mem.exists(k) ? mem[k] : dflt(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        logic [29:0] k = a[31:2];
        return gmem.exists(k) ? gmem[k] : dflt(a);
    endfunction

    function automatic bit in_rng(input logic [31:0] a);
        return (a >= START) && (a < END_A);
    endfunction

    always @(posedge clk) begin
        if (ram_en === 1'b1) begin
            if (ram_we) begin
                logic [31:0] w;
                w = mem_rd(ram_addr);
                for (int b = 0; b < 4; b++) if (ram_be[b]) w[8*b +: 8] = ram_wdata[8*b +: 8];
                mem[ram_addr[31:2]] = w;
            end else begin
                ram_rdata <= mem_rd(ram_addr);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0; core_be = 0;
        dbg_start = 0; dbg_addr = 0; dbg_len = 0;
    endtask

    task automatic gwrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] w;
        w = ref_rd(a);
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
        gmem[a[31:2]] = w;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1; tick(); tick(); rst = 0;
        @(negedge clk);
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", outs); end
        tick();
    endtask

    task automatic test_core_rw();
        core_req = 1; core_we = 1; core_addr = START + 8; core_wdata = 32'hDEAD_BEEF; core_be = 4'hF;
        @(negedge clk);
        checks++;
        if (core_gnt !== 1'b1) begin errors++; $display("FAIL core_wr_gnt: got %b want 1", core_gnt); end
        checks++;
        if ({ram_en, ram_we, ram_addr, ram_wdata, ram_be} !== {1'b1, 1'b1, START + 32'd8, 32'hDEAD_BEEF, 4'hF}) begin
            errors++; $display("FAIL core_wr_strobe: got %b %b %h %h %h", ram_en, ram_we, ram_addr, ram_wdata, ram_be);
        end
        gwrite(START + 8, 32'hDEAD_BEEF, 4'hF);
        tick();
        core_we = 0; core_wdata = 0;
        @(negedge clk);
        checks++;
        if (core_gnt !== 1'b1) begin errors++; $display("FAIL core_rd_gnt: got %b want 1", core_gnt); end
        checks++;
        if (core_rvalid !== 1'b0) begin errors++; $display("FAIL core_no_rvalid_after_write: got %b want 0", core_rvalid); end
        checks++;
        if ({ram_en, ram_we} !== 2'b10) begin errors++; $display("FAIL core_rd_strobe: got %b%b want 10", ram_en, ram_we); end
        tick();
        idle_inputs();
        @(negedge clk);
        checks++;
        if ({core_rvalid, core_err, core_rdata} !== {2'b10, 32'hDEAD_BEEF}) begin
            errors++; $display("FAIL core_rd_resp: got %b %b %h want 1 0 deadbeef", core_rvalid, core_err, core_rdata);
        end
        tick();
    endtask

    task automatic test_dbg_burst();
        dbg_start = 1; dbg_addr = START + 2; dbg_len = 4;
        @(negedge clk);
        checks++;
        if (dbg_busy !== 1'b0) begin errors++; $display("FAIL burst_busy_start_cycle: got %b want 0", dbg_busy); end
        tick();
        dbg_start = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({ram_en, ram_we, ram_addr, ram_be} !== {2'b10, START + 32'(4 * i), 4'hF}) begin
                errors++; $display("FAIL burst_beat%0d: got %b %b %h %h want addr %h", i, ram_en, ram_we, ram_addr, ram_be, START + 32'(4 * i));
            end
            checks++;
            if (dbg_rvalid !== (i > 0) || (i > 0 && dbg_rdata !== ref_rd(START + 32'(4 * (i - 1))))) begin
                errors++; $display("FAIL burst_rvalid%0d: got %b %h", i, dbg_rvalid, dbg_rdata);
            end
            checks++;
            if ({dbg_busy, dbg_done} !== 2'b10) begin errors++; $display("FAIL burst_busy%0d: got %b%b want 10", i, dbg_busy, dbg_done); end
            tick();
        end
        @(negedge clk);
        checks++;
        if ({dbg_rvalid, dbg_rdata, dbg_done, dbg_err, dbg_busy, ram_en} !== {1'b1, ref_rd(START + 12), 4'b1010}) begin
            errors++; $display("FAIL burst_drain: got rv=%b d=%h done=%b err=%b busy=%b en=%b", dbg_rvalid, dbg_rdata, dbg_done, dbg_err, dbg_busy, ram_en);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({dbg_busy, dbg_done, dbg_rvalid} !== 3'b000) begin errors++; $display("FAIL burst_after: got %b%b%b want 000", dbg_busy, dbg_done, dbg_rvalid); end
        tick();
    endtask

    task automatic test_starvation();
        int beats = 0;
        int done_c = 0;
        core_req = 1; core_we = 0; core_addr = START + 32'h20;
        dbg_start = 1; dbg_addr = START + 32'h40; dbg_len = 3;
        tick();
        dbg_start = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            checks++;
            if (core_rvalid && dbg_rvalid) begin errors++; $display("FAIL starve_dual_rvalid c%0d: got 11 want not both", c); end
            if (c <= 15) begin
                checks++;
                if (core_gnt !== ((c % 5) != 0)) begin errors++; $display("FAIL starve_pattern c%0d: got %b want %b", c, core_gnt, (c % 5) != 0); end
                if ((c % 5) == 0) begin
                    checks++;
                    if (ram_addr !== START + 32'h40 + 32'(4 * beats)) begin
                        errors++; $display("FAIL starve_beat_addr c%0d: got %h want %h", c, ram_addr, START + 32'h40 + 32'(4 * beats));
                    end
                    beats++;
                end
            end
            if (dbg_done === 1'b1 && done_c == 0) done_c = c;
            tick();
            if (done_c != 0) break;
        end
        idle_inputs();
        checks++;
        if (done_c != 16) begin errors++; $display("FAIL starve_done_cycle: got %0d want 16", done_c); end
        tick();
    endtask

    task automatic test_range_err();
        int nrv = 0;
        int done_c = 0;
        bit derr = 0;
        bit bad_en = 0;
        core_req = 1; core_we = 0; core_addr = END_A;
        @(negedge clk);
        checks++;
        if ({core_gnt, ram_en} !== 2'b10) begin errors++; $display("FAIL core_oor_grant: got %b%b want 10", core_gnt, ram_en); end
        tick();
        idle_inputs();
        @(negedge clk);
        checks++;
        if ({core_rvalid, core_err, core_rdata, ram_en} !== {2'b11, 32'h0, 1'b0}) begin
            errors++; $display("FAIL core_oor_resp: got %b %b %h %b", core_rvalid, core_err, core_rdata, ram_en);
        end
        tick();
        dbg_start = 1; dbg_addr = END_A - 8; dbg_len = 4;
        tick();
        dbg_start = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (dbg_rvalid === 1'b1) nrv++;
            if (ram_en === 1'b1 && !in_rng(ram_addr)) bad_en = 1;
            if (dbg_done === 1'b1) begin done_c = c; derr = dbg_err; end
            tick();
            if (done_c != 0) break;
        end
        checks++;
        if (nrv != 2) begin errors++; $display("FAIL dbg_oor_rvalids: got %0d want 2", nrv); end
        checks++;
        if (done_c != 4 || derr !== 1'b1) begin errors++; $display("FAIL dbg_oor_done: got cycle %0d err %b want 4 1", done_c, derr); end
        checks++;
        if (bad_en) begin errors++; $display("FAIL dbg_oor_strobe: got 1 want 0"); end
    endtask

    task automatic test_len0();
        dbg_start = 1; dbg_addr = START; dbg_len = 0;
        tick();
        dbg_start = 0;
        @(negedge clk);
        checks++;
        if ({dbg_done, dbg_err, dbg_busy, ram_en} !== 4'b1010) begin
            errors++; $display("FAIL len0_done: got %b%b%b%b want 1010", dbg_done, dbg_err, dbg_busy, ram_en);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({dbg_done, dbg_busy} !== 2'b00) begin errors++; $display("FAIL len0_after: got %b%b want 00", dbg_done, dbg_busy); end
        tick();
    endtask

    task automatic test_start_busy();
        dbg_start = 1; dbg_addr = START + 32'h80; dbg_len = 2;
        tick();
        dbg_addr = END_A; dbg_len = 5;
        @(negedge clk);
        checks++;
        if ({ram_en, ram_addr} !== {1'b1, START + 32'h80}) begin errors++; $display("FAIL busy_beat0: got %b %h", ram_en, ram_addr); end
        tick();
        dbg_start = 0;
        @(negedge clk);
        checks++;
        if ({ram_en, ram_addr} !== {1'b1, START + 32'h84}) begin errors++; $display("FAIL busy_beat1: got %b %h", ram_en, ram_addr); end
        tick();
        dbg_start = 1; dbg_addr = START; dbg_len = 1;
        @(negedge clk);
        checks++;
        if ({dbg_done, dbg_err, dbg_rvalid} !== 3'b101) begin errors++; $display("FAIL busy_done: got %b%b%b want 101", dbg_done, dbg_err, dbg_rvalid); end
        tick();
        dbg_start = 0;
        @(negedge clk);
        checks++;
        if ({dbg_busy, ram_en} !== 2'b00) begin errors++; $display("FAIL busy_start_in_done_ignored: got %b%b want 00", dbg_busy, ram_en); end
        tick();
        @(negedge clk);
        checks++;
        if ({dbg_busy, dbg_done} !== 2'b00) begin errors++; $display("FAIL busy_no_second_burst: got %b%b want 00", dbg_busy, dbg_done); end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid_burst();
        bit stray = 0;
        int nrv = 0;
        int done_c = 0;
        dbg_start = 1; dbg_addr = START; dbg_len = 8;
        tick();
        dbg_start = 0;
        tick(); tick(); tick();
        rst = 1;
        tick();
        rst = 0;
        @(negedge clk);
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL reset_mid_outputs: got %h want 0", outs); end
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            if (dbg_done !== 1'b0 || dbg_busy !== 1'b0 || dbg_rvalid !== 1'b0) stray = 1;
            tick();
        end
        checks++;
        if (stray) begin errors++; $display("FAIL reset_mid_no_done: got activity want none"); end
        dbg_start = 1; dbg_addr = START + 32'hC0; dbg_len = 2;
        tick();
        dbg_start = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (dbg_rvalid === 1'b1) nrv++;
            if (dbg_done === 1'b1) done_c = c;
            tick();
            if (done_c != 0) break;
        end
        checks++;
        if (nrv != 2 || done_c != 3) begin errors++; $display("FAIL reset_mid_restart: got rv=%0d done@%0d want 2 3", nrv, done_c); end
    endtask

    // Reference model: pending beats as an address queue, one expected response slot
    logic [31:0] m_beats[$];
    bit          m_busy = 0, m_done = 0, m_derr = 0;
    int          m_streak = 0;
    bit          m_rv = 0, m_rdbg = 0, m_rerr = 0;
    logic [31:0] m_rdata = 0;
    bit          e_pend, e_core_gnt, e_dbg_gnt, e_ram_en, e_ram_we;
    logic [31:0] e_ram_addr, e_ram_wdata;
    logic [3:0]  e_ram_be;

    task automatic model_eval();
        e_pend     = (m_beats.size() > 0);
        e_core_gnt = !rst && core_req && !(e_pend && m_streak == MAXS);
        e_dbg_gnt  = !rst && e_pend && !e_core_gnt;
        e_ram_en = 0; e_ram_we = 0; e_ram_addr = 0; e_ram_wdata = 0; e_ram_be = 0;
        if (e_core_gnt && in_rng(core_addr)) begin
            e_ram_en = 1; e_ram_we = core_we; e_ram_addr = core_addr; e_ram_wdata = core_wdata; e_ram_be = core_be;
        end else if (e_dbg_gnt && in_rng(m_beats[0])) begin
            e_ram_en = 1; e_ram_addr = m_beats[0]; e_ram_be = 4'hF;
        end
    endtask

    task automatic model_advance();
        bit nd = 0, nderr = 0, nb;
        logic [31:0] a;
        if (rst) begin
            m_beats.delete();
            m_busy = 0; m_done = 0; m_derr = 0; m_streak = 0; m_rv = 0; m_rdbg = 0; m_rerr = 0; m_rdata = 0;
            return;
        end
        m_rv = 0; m_rdbg = 0; m_rerr = 0; m_rdata = 0;
        if (e_core_gnt) begin
            if (!in_rng(core_addr)) begin m_rv = 1; m_rerr = 1; end
            else if (core_we) gwrite(core_addr, core_wdata, core_be);
            else begin m_rv = 1; m_rdata = ref_rd(core_addr); end
        end
        if (e_dbg_gnt) begin
            a = m_beats.pop_front();
            if (in_rng(a)) begin
                m_rv = 1; m_rdbg = 1; m_rdata = ref_rd(a);
                if (m_beats.size() == 0) nd = 1;
            end else begin
                m_beats.delete(); nd = 1; nderr = 1;
            end
        end
        if (!e_pend || e_dbg_gnt) m_streak = 0;
        else if (e_core_gnt && m_streak < MAXS) m_streak++;
        nb = m_busy && !m_done;
        if (dbg_start && !m_busy) begin
            nb = 1;
            for (int i = 0; i < int'(dbg_len); i++) begin
                a = (dbg_addr & ~32'd3) + 32'(4 * i);
                m_beats.push_back(a);
                if (!in_rng(a)) break;
            end
            if (dbg_len == 0) nd = 1;
        end
        m_busy = nb; m_done = nd; m_derr = nderr;
    endtask

    function automatic logic [31:0] pick_core_addr();
        case ($urandom_range(0, 3))
            0: return START + 32'(4 * $urandom_range(0, 31));
            1: return END_A - 32'(4 * $urandom_range(1, 3));
            2: return END_A + 32'(4 * $urandom_range(0, 2));
            default: return START - 32'd4;
        endcase
    endfunction

    function automatic logic [31:0] pick_dbg_addr();
        case ($urandom_range(0, 3))
            1: return END_A - 32'(4 * $urandom_range(0, 4)) + 32'($urandom_range(0, 3));
            2: return 32'hFFFF_FFF8;
            default: return START + 32'($urandom_range(0, 127));
        endcase
    endfunction

    task automatic test_random();
        bit hold = 0;
        bit crv, drv;
        for (int n = 0; n < 800; n++) begin
            rst = (n == 0) || ($urandom_range(0, 199) == 0);
            if (!hold) begin
                core_req = ($urandom_range(0, 1) == 1); core_we = ($urandom_range(0, 2) == 0);
                core_addr = pick_core_addr(); core_wdata = $urandom; core_be = 4'($urandom_range(0, 15));
            end
            dbg_start = ($urandom_range(0, 9) == 0);
            if (dbg_start) begin dbg_addr = pick_dbg_addr(); dbg_len = 8'($urandom_range(0, 6)); end
            @(negedge clk);
            model_eval();
            crv = m_rv && !m_rdbg;
            drv = m_rv && m_rdbg;
            checks++;
            if (core_gnt !== e_core_gnt) begin errors++; $display("FAIL rnd_core_gnt n%0d: got %b want %b", n, core_gnt, e_core_gnt); end
            checks++;
            if (ram_en !== e_ram_en) begin errors++; $display("FAIL rnd_ram_en n%0d: got %b want %b", n, ram_en, e_ram_en); end
            if (e_ram_en) begin
                checks++;
                if ({ram_we, ram_addr, ram_be, ram_wdata} !== {e_ram_we, e_ram_addr, e_ram_be, e_ram_wdata}) begin
                    errors++; $display("FAIL rnd_ram_req n%0d: got %b %h %h %h want %b %h %h %h", n, ram_we, ram_addr, ram_be, ram_wdata, e_ram_we, e_ram_addr, e_ram_be, e_ram_wdata);
                end
            end
            checks++;
            if ({core_rvalid, core_err} !== {crv, crv && m_rerr}) begin errors++; $display("FAIL rnd_core_rvalid n%0d: got %b%b want %b%b", n, core_rvalid, core_err, crv, crv && m_rerr); end
            checks++;
            if (core_rdata !== (crv ? m_rdata : 32'h0)) begin errors++; $display("FAIL rnd_core_rdata n%0d: got %h want %h", n, core_rdata, crv ? m_rdata : 32'h0); end
            checks++;
            if (dbg_rvalid !== drv) begin errors++; $display("FAIL rnd_dbg_rvalid n%0d: got %b want %b", n, dbg_rvalid, drv); end
            checks++;
            if (dbg_rdata !== (drv ? m_rdata : 32'h0)) begin errors++; $display("FAIL rnd_dbg_rdata n%0d: got %h want %h", n, dbg_rdata, drv ? m_rdata : 32'h0); end
            checks++;
            if ({dbg_busy, dbg_done, dbg_err} !== {m_busy, m_done, m_done && m_derr}) begin
                errors++; $display("FAIL rnd_dbg_status n%0d: got %b%b%b want %b%b%b", n, dbg_busy, dbg_done, dbg_err, m_busy, m_done, m_done && m_derr);
            end
            hold = core_req && !e_core_gnt;
            @(posedge clk);
            model_advance();
            #1;
        end
        rst = 0;
        idle_inputs();
        tick();
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_core_rw();
        test_dbg_burst();
        test_starvation();
        test_range_err();
        test_len0();
        test_start_busy();
        test_reset_mid_burst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
